// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the decimal line parser.
// Holds the ASCII codes it reacts to and the 16-bit saturation limit.
package uart_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_DEL = 8'h7F;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;

  localparam logic [15:0] SAT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CONVERT = 2'd2,
    S_OUTPUT  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_dec_line_parser_echo_fifo.sv
// Small circular FIFO holding bytes to echo back to the UART transmitter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module echo_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] OCC_FULL = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      occ_q, occ_d;
  logic             do_push, do_pop;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OCC_FULL);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + (PW + 1)'(1);
      2'b01:   occ_d = occ_q - (PW + 1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_dec_line_parser.sv
// Collects ASCII decimal digits from a UART stream, echoes accepted edits,
// and converts the line to a saturated 16-bit unsigned number on CR.
module uart_dec_line_parser
  import uart_pkg::*;
#(
  parameter int MAX_DIGITS = 5,
  parameter int ECHO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        arm,
  output logic        num_valid,
  input  logic        num_ready,
  output logic [15:0] num_value,
  output logic        num_ovf,
  output logic        echo_valid,
  input  logic        echo_ready,
  output logic [7:0]  echo_byte,
  output logic        busy
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [15:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      num_value_q, num_value_d;
  logic [3:0]       digit_q [MAX_DIGITS];
  logic [3:0]       digit_d [MAX_DIGITS];

  logic       echo_empty, echo_full, echo_pop, echo_push, echo_room;
  logic [7:0] echo_push_data;
  logic       is_digit, is_erase;
  logic [16:0] step;

  // One multiply-accumulate step; the wide intermediate covers acc*10+9 for
  // any acc, and once saturated the result stays pinned at the limit.
  function automatic logic [16:0] sat_step(input logic [15:0] acc,
                                           input logic [3:0]  dig,
                                           input logic        sticky);
    logic [19:0] wide;
    wide = ({4'b0, acc} * 20'd10) + {16'b0, dig};
    if (sticky || (wide > {4'b0, SAT_MAX})) return {1'b1, SAT_MAX};
    return {1'b0, wide[15:0]};
  endfunction

  assign echo_valid = !echo_empty;
  assign echo_pop   = echo_valid && echo_ready;
  assign echo_room  = !echo_full || echo_pop;
  assign is_digit   = (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);
  assign is_erase   = (rx_byte == ASCII_BS) || (rx_byte == ASCII_DEL);
  assign step       = sat_step(acc_q, digit_q[idx_q], ovf_q);

  assign num_valid = (state_q == S_OUTPUT);
  assign busy      = (state_q != S_IDLE);
  assign num_value = num_value_q;
  assign num_ovf   = ovf_q;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    ovf_d          = ovf_q;
    num_value_d    = num_value_q;
    digit_d        = digit_q;
    echo_push      = 1'b0;
    echo_push_data = rx_byte;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d = S_COLLECT;
          count_d = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_COLLECT: begin
        if (rx_valid) begin
          if (is_digit) begin
            if ((count_q < MAX_CNT) && echo_room) begin
              digit_d[count_q] = rx_byte[3:0];
              count_d          = count_q + CNT_ONE;
              echo_push        = 1'b1;
            end
          end else if (is_erase) begin
            if ((count_q != '0) && echo_room) begin
              count_d        = count_q - CNT_ONE;
              echo_push      = 1'b1;
              echo_push_data = ASCII_BS;
            end
          end else if ((rx_byte == ASCII_CR) && (count_q != '0)) begin
            state_d = S_CONVERT;
            idx_d   = '0;
          end
        end
      end
      S_CONVERT: begin
        acc_d = step[15:0];
        ovf_d = step[16];
        idx_d = idx_q + CNT_ONE;
        if (idx_q == (count_q - CNT_ONE)) begin
          state_d     = S_OUTPUT;
          num_value_d = step[15:0];
        end
      end
      S_OUTPUT: begin
        if (num_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      num_value_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      num_value_q <= num_value_d;
    end
  end

  // Digit store is pure data; count_q decides which entries are meaningful.
  always_ff @(posedge clk) begin
    digit_q <= digit_d;
  end

  echo_fifo #(
    .WIDTH (8),
    .DEPTH (ECHO_DEPTH)
  ) u_echo_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (echo_push),
    .push_data (echo_push_data),
    .pop       (echo_pop),
    .head      (echo_byte),
    .empty     (echo_empty),
    .full      (echo_full)
  );

endmodule

// File: tb/tb_uart_dec_line_parser.sv
// Directed-vector bench for uart_dec_line_parser with hand-computed results.
module tb_uart_dec_line_parser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        arm;
  logic        num_valid;
  logic        num_ready;
  logic [15:0] num_value;
  logic        num_ovf;
  logic        echo_valid;
  logic        echo_ready;
  logic [7:0]  echo_byte;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] echo_q [$];

  always #5 clk = ~clk;

  uart_dec_line_parser #(
    .MAX_DIGITS (5),
    .ECHO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .arm        (arm),
    .num_valid  (num_valid),
    .num_ready  (num_ready),
    .num_value  (num_value),
    .num_ovf    (num_ovf),
    .echo_valid (echo_valid),
    .echo_ready (echo_ready),
    .echo_byte  (echo_byte),
    .busy       (busy)
  );

  // Record every echo byte the transmitter takes.
  always @(negedge clk) begin
    if (reset_n && echo_valid && echo_ready) echo_q.push_back(echo_byte);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic accept();
    num_ready = 1'b1;
    tick();
    num_ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (num_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(tag, {31'b0, seen}, 32'd1);
  endtask

  // exp holds the expected bytes with the first one in the most significant slot.
  task automatic check_echo(input string tag, input int n, input logic [63:0] exp);
    logic [31:0] got;
    check({tag, "_n"}, echo_q.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < echo_q.size()) ? {24'b0, echo_q[i]} : 32'hFFFF_FFFF;
      check(tag, got, {24'b0, exp[8*(n-1-i) +: 8]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    rx_valid   = 1'b0;
    rx_byte    = 8'h00;
    arm        = 1'b0;
    num_ready  = 1'b0;
    echo_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_num_valid", num_valid, 0);
    check("rst_echo_valid", echo_valid, 0);
    check("rst_num_value", num_value, 0);
    check("rst_num_ovf", num_ovf, 0);
    reset_n    = 1'b1;
    echo_ready = 1'b1;
    tick();

    // "123" CR: 123 = 0x7B, valid after three conversion edges
    echo_q.delete();
    do_arm();
    check("t1_busy", busy, 1);
    send_str("123");
    send(8'h0D);
    check("t1_lat0", num_valid, 0);
    tick();
    tick();
    check("t1_lat2", num_valid, 0);
    tick();
    check("t1_lat3", num_valid, 1);
    check("t1_value", num_value, 32'h7B);
    check("t1_ovf", num_ovf, 0);
    check_echo("t1_echo", 3, 64'h31_32_33);
    accept();
    check("t1_idle", busy, 0);

    // saturation boundary
    do_arm();
    send_str("65536");
    send(8'h0D);
    wait_valid("t2a_wait");
    check("t2a_value", num_value, 32'hFFFF);
    check("t2a_ovf", num_ovf, 1);
    accept();
    do_arm();
    check("t2_ovf_clr", num_ovf, 0);
    send_str("65535");
    send(8'h0D);
    wait_valid("t2b_wait");
    check("t2b_value", num_value, 32'hFFFF);
    check("t2b_ovf", num_ovf, 0);
    accept();

    // editing with backspace/delete; erase at count 0 is ignored
    echo_q.delete();
    do_arm();
    send_str("12");
    send(8'h08);
    send_str("9");
    send(8'h7F);
    send(8'h7F);
    send(8'h7F);
    send_str("7");
    send(8'h0D);
    wait_valid("t3_wait");
    check("t3_value", num_value, 32'h7);
    accept();
    check_echo("t3_echo", 7, 64'h31_32_08_39_08_08_37);

    // sixth digit dropped at MAX_DIGITS: 12345 = 0x3039
    echo_q.delete();
    do_arm();
    send_str("123456");
    send(8'h0D);
    wait_valid("t3b_wait");
    check("t3b_value", num_value, 32'h3039);
    accept();
    check_echo("t3b_echo", 5, 64'h31_32_33_34_35);

    // echo FIFO full: digits without echo room are dropped
    echo_ready = 1'b0;
    echo_q.delete();
    do_arm();
    send_str("123456");
    check("t4_echo_valid", echo_valid, 1);
    check("t4_echo_head", echo_byte, 32'h31);
    echo_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("t4_drained", echo_valid, 0);
    check_echo("t4_echo", 4, 64'h31_32_33_34);
    send(8'h0D);
    wait_valid("t4_wait");
    check("t4_value", num_value, 32'h4D2);
    accept();

    // reset in the second conversion cycle
    do_arm();
    send_str("999");
    send(8'h0D);
    tick();
    reset_n = 1'b0;
    tick();
    check("t5_busy", busy, 0);
    check("t5_num_valid", num_valid, 0);
    check("t5_echo_valid", echo_valid, 0);
    check("t5_num_value", num_value, 0);
    reset_n = 1'b1;
    echo_q.delete();
    send_str("5");
    send(8'h0D);
    for (int i = 0; i < 5; i++) tick();
    check("t5_post_busy", busy, 0);
    check("t5_post_valid", num_valid, 0);
    check("t5_post_echo", echo_q.size(), 0);

    // backpressure on the number output; arm ignored meanwhile
    do_arm();
    send_str("42");
    send(8'h0D);
    wait_valid("t6_wait");
    for (int i = 0; i < 10; i++) begin
      check("t6_hold_valid", num_valid, 1);
      check("t6_hold_value", num_value, 32'h2A);
      if (i == 4) arm = 1'b1;
      tick();
      arm = 1'b0;
    end
    accept();
    check("t6_idle", busy, 0);
    check("t6_valid_low", num_valid, 0);
    check("t6_value_kept", num_value, 32'h2A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
